timer_arbiter: RTL and testbench
================================

TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter: N, default 4, number of requesters.
REQ-002 Parameter: W, default 5, count-value width.
REQ-003 Parameter: SLACK, default 4, extra watchdog cycles allowed beyond the granted value.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: req  input  N  per-requester level request; held until the matching done or err pulse.
REQ-007 Port: req_value  input  N*W  packed count values; requester i occupies bits [i*W +: W].
REQ-008 Port: grant  output  N  one-hot owner of the shared timer; all zero when idle.
REQ-009 Port: done  output  N  one-cycle pulse to the owner on normal completion.
REQ-010 Port: err  output  N  one-cycle pulse to the owner on watchdog expiry.
REQ-011 Port: tmr_start  output  1  start strobe to the shared down-counter timer.
REQ-012 Port: tmr_value  output  W  count value to the shared timer.
REQ-013 Port: tmr_done  input  1  completion pulse from the shared timer.
REQ-014 Port: busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, START, WAIT and FINISH.
REQ-016 IDLE: if any req bit is high, the block SHALL select the winner round-robin, starting the search at index ptr; set grant; latch the winner's req_value; go to START.
REQ-017 START SHALL last exactly 2 cycles, with tmr_start=1 and tmr_value held at the latched value, then go to WAIT.
REQ-018 WAIT: tmr_start=0; the watchdog counter SHALL increment from 0 each cycle; tmr_done=1 goes to FINISH with done[owner] pulsed in that transition cycle.
REQ-019 WAIT: if the watchdog reaches latched value + SLACK + 2 without tmr_done, the block SHALL pulse err[owner] and go to FINISH; done SHALL NOT pulse.
REQ-020 Watchdog width SHALL be W+3 bits and its sum SHALL not overflow for any W-bit value with SLACK up to 7.
REQ-021 FINISH (1 cycle): grant SHALL be cleared; ptr SHALL become (owner+1) mod N; the FSM returns to IDLE, so arbitration latency is 1 cycle.
REQ-022 grant SHALL stay one-hot and constant from IDLE exit through FINISH.
REQ-023 done and err SHALL never both be high, and each SHALL be high only for the owner.
REQ-024 tmr_done seen outside WAIT SHALL be ignored.
REQ-025 If tmr_done and watchdog expiry occur in the same cycle, done SHALL win.
REQ-026 The owner dropping req during START or WAIT SHALL NOT abort the sequence; done or err still pulses.
REQ-027 Non-owner req changes SHALL NOT affect the current sequence.
REQ-028 Changes to req_value after the latch SHALL NOT change tmr_value.
REQ-029 tmr_value SHALL be the latched value in START and WAIT, and 0 otherwise.
REQ-030 req_value of 0 SHALL be legal and handled like any other value.

Reset
REQ-031 rst high SHALL asynchronously force state=IDLE, ptr=0, watchdog=0, latched value=0, grant=0, done=0, err=0, tmr_start=0, tmr_value=0 and busy=0.
REQ-032 Reset asserted mid-sequence SHALL abandon the sequence with no done or err pulse.
REQ-033 After reset deasserts, arbitration SHALL resume from index 0.

Verification
REQ-034 Single request: req=0001, value0=5, timer asserts tmr_done 7 cycles after START exit -> grant=0001; tmr_start high 2 cycles with tmr_value=5; done=0001 for 1 cycle; busy low 1 cycle after FINISH.
REQ-035 Round robin: req=1111 held, each timer completes -> grants in order 0001, 0010, 0100, 1000, 0001; no requester is granted twice before every other requester has been served.
REQ-036 Watchdog: value=3, SLACK=4, tmr_done never asserts -> err[owner] pulses on WAIT cycle 9; done stays 0; next requester is granted.
REQ-037 Collision: tmr_done arrives on the same cycle as watchdog expiry -> done pulses and err stays 0.
REQ-038 Reset mid-WAIT: rst pulsed while grant=0100 -> all outputs go 0 immediately; after release with req=1100, grant=0100 (search starts from ptr=0).
REQ-039 Value stability: req_value changed from 9 to 2 during WAIT -> tmr_value stays 9; a spurious tmr_done during IDLE produces no done pulse.

Source files
------------

// File: rtl/timer_arbiter.sv
// Round-robin owner of one shared down-counter timer; 2-cycle start strobe, watchdog-guarded wait, 1-cycle finish.
// Requests are levels held until done/err; a new grant follows FINISH after one IDLE arbitration cycle.
module timer_arbiter #(
    parameter int N     = 4,
    parameter int W     = 5,
    parameter int SLACK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   req_value,
    output logic [N-1:0]     grant,
    output logic [N-1:0]     done,
    output logic [N-1:0]     err,
    output logic             tmr_start,
    output logic [W-1:0]     tmr_value,
    input  logic             tmr_done,
    output logic             busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = W + 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   win;
    logic            found;
    int              idx;
    logic [W-1:0]    val;
    logic [CW-1:0]   wd;
    logic [CW-1:0]   limit;
    logic            wd_hit;
    logic            start_cnt;
    logic [N-1:0]    grant_q;

    // CW bits hold the largest W-bit value plus SLACK+2 without wrapping
    assign limit  = CW'(val) + CW'(SLACK + 2);
    assign wd_hit = ((wd + CW'(1)) == limit);

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = '0;
        err       = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (start_cnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // a timer completion on the expiry cycle still counts as normal completion
                if (tmr_done) begin
                    done      = grant_q;
                    state_nxt = FINISH;
                end else if (wd_hit) begin
                    err       = grant_q;
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            owner     <= '0;
            val       <= '0;
            wd        <= '0;
            start_cnt <= 1'b0;
            grant_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wd        <= '0;
                    start_cnt <= 1'b0;
                    if (found) begin
                        owner   <= win;
                        grant_q <= N'(1) << win;
                        val     <= req_value[int'(win)*W +: W];
                    end
                end
                START: begin
                    start_cnt <= 1'b1;
                    wd        <= '0;
                end
                WAIT: begin
                    wd <= wd + CW'(1);
                end
                FINISH: begin
                    grant_q <= '0;
                    wd      <= '0;
                    ptr     <= (owner == PW'(N - 1)) ? '0 : owner + PW'(1);
                end
                default: begin
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign tmr_start = (state == START);
    assign tmr_value = ((state == START) || (state == WAIT)) ? val : '0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter with a cycle-level reference model and literal scenario checks.
module tb_timer_arbiter;

    localparam int N     = 4;
    localparam int W     = 5;
    localparam int SLACK = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   req_value = '0;
    logic             tmr_done = 1'b0;
    logic [N-1:0]     grant;
    logic [N-1:0]     done;
    logic [N-1:0]     err;
    logic             tmr_start;
    logic [W-1:0]     tmr_value;
    logic             busy;

    timer_arbiter #(.N(N), .W(W), .SLACK(SLACK)) dut (
        .clk(clk), .rst(rst), .req(req), .req_value(req_value),
        .grant(grant), .done(done), .err(err),
        .tmr_start(tmr_start), .tmr_value(tmr_value),
        .tmr_done(tmr_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: owner index (-1 idle), cycles since grant, finishing flag
    int m_owner = -1;
    int m_age   = 0;
    int m_val   = 0;
    int m_ptr   = 0;
    bit m_fin   = 1'b0;

    int            n_start = 0;
    int            n_done  = 0;
    int            n_err   = 0;
    logic [W-1:0]  start_val = '0;
    logic [N-1:0]  last_done = '0;
    logic [N-1:0]  last_err  = '0;
    logic [N-1:0]  prev_grant = '0;
    logic [N-1:0]  glog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_out(output logic [N-1:0] g, output logic [N-1:0] d,
                                      output logic [N-1:0] e, output logic ts,
                                      output logic [W-1:0] tv, output logic b);
        g = '0; d = '0; e = '0; ts = 1'b0; tv = '0; b = 1'b0;
        if (rst || m_owner < 0) return;
        b = 1'b1;
        g[m_owner] = 1'b1;
        if (m_fin) return;
        tv = W'(m_val);
        if (m_age < 2) ts = 1'b1;
        else if (tmr_done) d[m_owner] = 1'b1;
        else if (m_age - 1 == m_val + SLACK + 2) e[m_owner] = 1'b1;
    endfunction

    task automatic model_loop();
        logic [N-1:0] g, d, e;
        logic ts, b;
        logic [W-1:0] tv;
        int idx;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_owner = -1; m_ptr = 0; m_fin = 1'b0; m_age = 0; m_val = 0;
            end else if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (m_owner < 0 && req[idx]) begin
                        m_owner = idx;
                        m_val   = int'(req_value[idx*W +: W]);
                        m_age   = 0;
                        m_fin   = 1'b0;
                    end
                end
            end else if (m_fin) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_fin   = 1'b0;
            end else begin
                model_out(g, d, e, ts, tv, b);
                if ((d | e) != 0) m_fin = 1'b1;
                else m_age++;
            end
        end
    endtask

    task automatic mon_loop();
        logic [N-1:0] g, d, e;
        logic ts, b;
        logic [W-1:0] tv;
        forever begin
            @(negedge clk);
            model_out(g, d, e, ts, tv, b);
            chk("cycle {grant,done,err,start,value,busy}",
                32'({grant, done, err, tmr_start, tmr_value, busy}),
                32'({g, d, e, ts, tv, b}));
            if (tmr_start) begin n_start++; start_val = tmr_value; end
            if (done != 0) begin n_done++; last_done = done; end
            if (err != 0) begin n_err++; last_err = err; end
            if (grant != 0 && prev_grant == 0) glog.push_back(grant);
            prev_grant = grant;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!tmr_start && n < 30) begin cyc(); n++; end
        if (!tmr_start) chk("start_timeout", 32'd0, 32'd1);
    endtask

    // d: WAIT cycle (1-based) on which tmr_done is driven, 0 = never
    task automatic run_timer(input int d, input bit hook, output int k_out, output logic [W-1:0] tv_end);
        k_out = 0;
        tv_end = '0;
        wait_start();
        if (!tmr_start) return;
        cyc();
        cyc();
        for (int k = 1; k <= 60; k++) begin
            if (hook && k == 2) begin
                req = '0;
                req_value[W +: W] = W'(2);
            end
            if (k == d) tmr_done = 1'b1;
            #1;
            if ((done | err) != 0) begin
                k_out = k;
                tv_end = tmr_value;
                cyc();
                tmr_done = 1'b0;
                return;
            end
            cyc();
            tmr_done = 1'b0;
        end
        chk("outcome_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int k;
        int g0, bd, be, bs;
        logic [W-1:0] tv;
        logic [N-1:0] rr[5];
        rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        fork
            model_loop();
            mon_loop();
            begin
                #100000;
                $display("FAIL global_timeout");
                $fatal(1, "bench timeout");
            end
        join_none

        repeat (2) cyc();
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        cyc();

        // single request, value 5, completion on WAIT cycle 7
        g0 = glog.size(); bd = n_done; be = n_err; bs = n_start;
        req_value[0 +: W] = W'(5);
        req = 4'b0001;
        run_timer(7, 1'b0, k, tv);
        req = '0;
        chk("single_k", 32'(k), 32'd7);
        chk("single_grant", 32'(glog[g0]), 32'b0001);
        chk("single_start_cycles", 32'(n_start - bs), 32'd2);
        chk("single_start_value", 32'(start_val), 32'd5);
        chk("single_done_bits", 32'(last_done), 32'b0001);
        chk("single_done_count", 32'(n_done - bd), 32'd1);
        chk("single_err_count", 32'(n_err - be), 32'd0);
        cyc();
        chk("single_busy_after", 32'(busy), 32'd0);

        // round robin from a fresh reset
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        g0 = glog.size();
        for (int i = 0; i < N; i++) req_value[i*W +: W] = W'(1);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) run_timer(3, 1'b0, k, tv);
        req = '0;
        for (int i = 0; i < 5; i++) chk($sformatf("rr_grant%0d", i), 32'(glog[g0+i]), 32'(rr[i]));

        // watchdog expiry on owner 1, then requester 2 (value 0) is served
        bd = n_done; be = n_err;
        req_value[W +: W] = W'(3);
        req_value[2*W +: W] = W'(0);
        req = 4'b0110;
        run_timer(0, 1'b0, k, tv);
        req = 4'b0100;
        chk("wdog_k", 32'(k), 32'd9);
        chk("wdog_err_bits", 32'(last_err), 32'b0010);
        chk("wdog_err_count", 32'(n_err - be), 32'd1);
        chk("wdog_done_count", 32'(n_done - bd), 32'd0);
        run_timer(2, 1'b0, k, tv);
        req = '0;
        chk("wdog_next_grant", 32'(glog[glog.size()-1]), 32'b0100);
        chk("zero_value_done", 32'(last_done), 32'b0100);

        // completion on the same cycle as expiry
        be = n_err;
        req_value[3*W +: W] = W'(3);
        req = 4'b1000;
        run_timer(9, 1'b0, k, tv);
        req = '0;
        chk("collide_k", 32'(k), 32'd9);
        chk("collide_done_bits", 32'(last_done), 32'b1000);
        chk("collide_err_count", 32'(n_err - be), 32'd0);

        // reset in the middle of WAIT
        req_value[2*W +: W] = W'(6);
        req = 4'b0100;
        wait_start();
        repeat (4) cyc();
        chk("midrst_grant_before", 32'(grant), 32'b0100);
        bd = n_done; be = n_err;
        rst = 1'b1;
        #1;
        chk("midrst_outputs", 32'({grant, done, err, tmr_start, tmr_value, busy}), 32'd0);
        cyc();
        rst = 1'b0;
        req_value[3*W +: W] = W'(1);
        req = 4'b1100;
        g0 = glog.size();
        run_timer(2, 1'b0, k, tv);
        req = '0;
        chk("midrst_regrant", 32'(glog[g0]), 32'b0100);
        chk("midrst_done_count", 32'(n_done - bd), 32'd1);
        chk("midrst_err_count", 32'(n_err - be), 32'd0);

        // value change and owner drop during WAIT, then spurious tmr_done in IDLE
        req_value[W +: W] = W'(9);
        req = 4'b0010;
        run_timer(4, 1'b1, k, tv);
        chk("stable_k", 32'(k), 32'd4);
        chk("stable_value", 32'(tv), 32'd9);
        chk("stable_done_bits", 32'(last_done), 32'b0010);
        cyc();
        bd = n_done;
        tmr_done = 1'b1;
        cyc();
        tmr_done = 1'b0;
        repeat (2) cyc();
        chk("spurious_done_count", 32'(n_done - bd), 32'd0);
        chk("spurious_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
